dmem_store_buffer: RTL and testbench
====================================

Name: dmem_store_buffer

Overview:
- Posted-write store buffer between the processor's Memory-stage data port and the data RAM.
- Captures stores (memw_m, m_address, m_data) into a FIFO in one cycle and drains them to the RAM through a valid/ready write port.
- Returns load data on input_data combinationally, with store-to-load forwarding from buffered entries so the pipeline never reads stale memory.

Parameters:
DEPTH, 4, number of buffered stores (power of 2, >=2)
ADDR_W, 32, address width (byte address, word aligned)
DATA_W, 32, data width

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous reset, active-low
memw_m  input  1  store request from Memory stage
m_address  input  ADDR_W  load/store byte address
m_data  input  DATA_W  store data
input_data  output  DATA_W  load data to pipeline, combinational
mem_rd_addr  output  ADDR_W  RAM async read address
mem_rd_data  input  DATA_W  RAM async read data
mem_wr_valid  output  1  head store pending
mem_wr_ready  input  1  RAM accepts head store
mem_wr_addr  output  ADDR_W  head store address
mem_wr_data  output  DATA_W  head store data
full  output  1  count == DEPTH
empty  output  1  count == 0
overflow  output  1  sticky: a store was dropped

Behaviour:
- Reset (rst low, async):
  - wr_ptr, rd_ptr and count = 0; all entries invalid.
  - Outputs: mem_wr_valid=0, full=0, empty=1, overflow=0.
  - Buffered stores are discarded, including a mid-handshake head.
- Address match uses addr[ADDR_W-1:2] only. Bits [1:0] are ignored but stored unchanged.
- Enqueue: occurs on a rising edge with memw_m=1 when count<DEPTH, or when count==DEPTH and the head pops in the same cycle.
- Overflow: memw_m=1 with count==DEPTH and no pop drops the store and sets overflow. overflow stays set until reset.
- Write-port output:
  - mem_wr_valid = !empty.
  - mem_wr_addr/mem_wr_data = head entry; stable while valid && !ready.
  - Pop on the edge where mem_wr_valid && mem_wr_ready.
  - mem_wr_valid must not depend combinationally on mem_wr_ready.
- Count update:
  - Enqueue only: +1.
  - Pop only: -1.
  - Enqueue and pop together: unchanged.
  - Pointers wrap modulo DEPTH.
- Latency:
  - A store is visible on mem_wr_valid in the cycle after memw_m at the earliest; there is no bypass around an empty buffer.
  - A store is visible to forwarding from the cycle after capture.
- Read path:
  - mem_rd_addr = m_address, always.
  - input_data = data of the newest valid entry whose word address matches m_address; otherwise mem_rd_data.
  - The entry popping this cycle still forwards this cycle.
  - The store arriving this cycle (memw_m) is not forwarded.
- full and empty are registered-state decodes of count.
- Transparent when idle: with empty=1, input_data == mem_rd_data.

Optional Feature:
Macro: DMEM_STORE_MERGE_EN
- Defined: memw_m=1 whose word address matches a valid non-head entry overwrites the newest such entry's data and full address.
  - No enqueue; count unchanged.
  - Allowed when full; does not set overflow.
  - A match on the head only (head may be mid-handshake) enqueues normally.
- Undefined: every store enqueues a new entry; duplicate addresses coexist and newest-match forwarding resolves loads.

Test Plan:
1. Reset then idle, mem_rd_data=0xDEADBEEF, m_address=0x10 -> input_data=0xDEADBEEF, empty=1, mem_wr_valid=0.
2. Store 0x40<-0x11111111, mem_wr_ready=0 -> next cycle mem_wr_valid=1, mem_wr_addr=0x40, mem_wr_data=0x11111111. Load 0x40 (also 0x42) -> input_data=0x11111111. Hold ready=0 for 3 cycles -> head stable.
3. Stores 0x80<-1 then 0x80<-2, ready=0 -> load 0x80 returns 2. Merge on: count=1 when the first is not head-only, count=2 otherwise. Merge off: count=2; drain order 1 then 2.
4. Fill DEPTH=4 stores with ready=0 -> full=1. A 5th store -> dropped, overflow=1, count=4. Repeat with ready=1 in the same cycle -> accepted, count stays 4, overflow=0.
5. Continuous stores with ready=1 every cycle -> count stays at most 1, RAM receives all in order, no overflow.
6. Assert rst low mid-handshake with 3 entries -> immediately mem_wr_valid=0, empty=1. After release, load of a previously buffered address returns mem_rd_data.

Source files
------------

// File: rtl/dmem_store_buffer.sv
// rtl/dmem_store_buffer.sv - posted-write store buffer with store-to-load forwarding (optional: DMEM_STORE_MERGE_EN)
module dmem_store_buffer #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              memw_m,
  input  logic [ADDR_W-1:0] m_address,
  input  logic [DATA_W-1:0] m_data,
  output logic [DATA_W-1:0] input_data,
  output logic [ADDR_W-1:0] mem_rd_addr,
  input  logic [DATA_W-1:0] mem_rd_data,
  output logic              mem_wr_valid,
  input  logic              mem_wr_ready,
  output logic [ADDR_W-1:0] mem_wr_addr,
  output logic [DATA_W-1:0] mem_wr_data,
  output logic              full,
  output logic              empty,
  output logic              overflow
);

  localparam int PW = $clog2(DEPTH);

  logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [PW:0]       count_q, count_d;
  logic              overflow_q, overflow_d;
  logic [ADDR_W-1:0] addr_q [DEPTH];
  logic [DATA_W-1:0] data_q [DEPTH];

  logic              pop;
  logic              push;
  logic              merge_hit;
  logic [PW-1:0]     fwd_idx;
`ifdef DMEM_STORE_MERGE_EN
  logic [PW-1:0]     merge_idx;
  logic [PW-1:0]     scan_idx;
`endif

  // Status and write-port outputs decode registered state only, so valid never sees ready.
  assign empty        = (count_q == '0);
  assign full         = (count_q == (PW+1)'(DEPTH));
  assign overflow     = overflow_q;
  assign mem_wr_valid = !empty;
  assign mem_wr_addr  = addr_q[rd_ptr_q];
  assign mem_wr_data  = data_q[rd_ptr_q];
  assign mem_rd_addr  = m_address;

  // Forwarding: walk oldest to newest so the newest matching valid entry wins.
  always_comb begin
    input_data = mem_rd_data;
    fwd_idx    = rd_ptr_q;
    for (int i = 0; i < DEPTH; i++) begin
      fwd_idx = rd_ptr_q + PW'(i);
      if (((PW+1)'(i) < count_q) &&
          (addr_q[fwd_idx][ADDR_W-1:2] == m_address[ADDR_W-1:2])) begin
        input_data = data_q[fwd_idx];
      end
    end
  end

`ifdef DMEM_STORE_MERGE_EN
  // Merge lookup skips the head, which may already be in a RAM handshake.
  always_comb begin
    merge_hit = 1'b0;
    merge_idx = '0;
    scan_idx  = rd_ptr_q;
    for (int i = 1; i < DEPTH; i++) begin
      scan_idx = rd_ptr_q + PW'(i);
      if (memw_m && ((PW+1)'(i) < count_q) &&
          (addr_q[scan_idx][ADDR_W-1:2] == m_address[ADDR_W-1:2])) begin
        merge_hit = 1'b1;
        merge_idx = scan_idx;
      end
    end
  end
`else
  assign merge_hit = 1'b0;
`endif

  // Enqueue/pop decisions and next-state pointer/count/overflow.
  always_comb begin
    pop        = mem_wr_valid && mem_wr_ready;
    push       = memw_m && !merge_hit && (!full || pop);
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    unique case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
    if (memw_m && !merge_hit && full && !pop) overflow_d = 1'b1;
  end

  // Control state register; reset discards every buffered store.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  // Entry storage; validity comes from count, so payload needs no reset.
  always_ff @(posedge clk) begin
    if (push) begin
      addr_q[wr_ptr_q] <= m_address;
      data_q[wr_ptr_q] <= m_data;
    end
`ifdef DMEM_STORE_MERGE_EN
    else if (merge_hit) begin
      addr_q[merge_idx] <= m_address;
      data_q[merge_idx] <= m_data;
    end
`endif
  end

endmodule

// File: tb/tb_dmem_store_buffer.sv
// tb/tb_dmem_store_buffer.sv - randomized self-checking bench for dmem_store_buffer
module tb_dmem_store_buffer;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        memw_m = 1'b0;
  logic [31:0] m_address = '0;
  logic [31:0] m_data = '0;
  logic [31:0] input_data;
  logic [31:0] mem_rd_addr;
  logic [31:0] mem_rd_data = '0;
  logic        mem_wr_valid;
  logic        mem_wr_ready = 1'b0;
  logic [31:0] mem_wr_addr;
  logic [31:0] mem_wr_data;
  logic        full;
  logic        empty;
  logic        overflow;

  dmem_store_buffer #(.DEPTH(DEPTH), .ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .rst(rst), .memw_m(memw_m), .m_address(m_address), .m_data(m_data),
    .input_data(input_data), .mem_rd_addr(mem_rd_addr), .mem_rd_data(mem_rd_data),
    .mem_wr_valid(mem_wr_valid), .mem_wr_ready(mem_wr_ready), .mem_wr_addr(mem_wr_addr),
    .mem_wr_data(mem_wr_data), .full(full), .empty(empty), .overflow(overflow)
  );

  always #5 clk = ~clk;

  logic [31:0] qa[$];
  logic [31:0] qd[$];
  bit          ovf_m = 1'b0;
  int          n_cmp = 0;
  int          n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] model_load(input logic [31:0] a, input logic [31:0] rd);
    for (int i = qa.size() - 1; i >= 0; i--)
      if (qa[i][31:2] == a[31:2]) return qd[i];
    return rd;
  endfunction

  task automatic check_model();
    chk("wr_valid", {31'b0, mem_wr_valid}, {31'b0, qa.size() != 0});
    if (qa.size() != 0) begin
      chk("wr_addr", mem_wr_addr, qa[0]);
      chk("wr_data", mem_wr_data, qd[0]);
    end
    chk("full", {31'b0, full}, {31'b0, qa.size() == DEPTH});
    chk("empty", {31'b0, empty}, {31'b0, qa.size() == 0});
    chk("overflow", {31'b0, overflow}, {31'b0, ovf_m});
    chk("input_data", input_data, model_load(m_address, mem_rd_data));
    chk("rd_addr", mem_rd_addr, m_address);
  endtask

  task automatic model_update();
    bit pop;
    bit push;
    int hi;
    pop = (qa.size() != 0) && mem_wr_ready;
    hi  = -1;
`ifdef DMEM_STORE_MERGE_EN
    if (memw_m)
      for (int i = 1; i < qa.size(); i++)
        if (qa[i][31:2] == m_address[31:2]) hi = i;
`endif
    push = memw_m && (hi < 0) && ((qa.size() < DEPTH) || pop);
    if (hi >= 0) begin
      qa[hi] = m_address;
      qd[hi] = m_data;
    end else if (memw_m && (qa.size() == DEPTH) && !pop) begin
      ovf_m = 1'b1;
    end
    if (pop) begin
      void'(qa.pop_front());
      void'(qd.pop_front());
    end
    if (push) begin
      qa.push_back(m_address);
      qd.push_back(m_data);
    end
  endtask

  task automatic drive(input bit w, input logic [31:0] a, input logic [31:0] d,
                       input bit rdy, input logic [31:0] rd);
    memw_m = w; m_address = a; m_data = d; mem_wr_ready = rdy; mem_rd_data = rd;
  endtask

  task automatic step();
    #1;
    check_model();
    @(posedge clk);
    if (rst) model_update();
    @(negedge clk);
  endtask

  task automatic async_reset();
    #2;
    rst = 1'b0;
    qa.delete();
    qd.delete();
    ovf_m = 1'b0;
    #1;
    chk("rst_wr_valid", {31'b0, mem_wr_valid}, 32'd0);
    chk("rst_empty", {31'b0, empty}, 32'd1);
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    drive(0, 32'h10, 0, 0, 32'hDEADBEEF);
    #1;
    chk("reset_empty", {31'b0, empty}, 32'd1);
    chk("reset_full", {31'b0, full}, 32'd0);
    chk("reset_valid", {31'b0, mem_wr_valid}, 32'd0);
    chk("reset_ovf", {31'b0, overflow}, 32'd0);
    @(negedge clk);
    rst = 1'b1;

    // 1: transparent when idle
    drive(0, 32'h10, 0, 0, 32'hDEADBEEF);
    #1 chk("idle_load", input_data, 32'hDEADBEEF);
    step();

    // 2: single store, head held stable while ready is low
    drive(1, 32'h40, 32'h11111111, 0, 32'hDEADBEEF);
    step();
    drive(0, 32'h42, 0, 0, 32'hDEADBEEF);
    #1;
    chk("t2_valid", {31'b0, mem_wr_valid}, 32'd1);
    chk("t2_addr", mem_wr_addr, 32'h40);
    chk("t2_fwd", input_data, 32'h11111111);
    for (int i = 0; i < 3; i++) step();
    chk("t2_hold", mem_wr_data, 32'h11111111);
    drive(0, 32'h40, 0, 1, 32'h0);
    step();

    // 3: duplicate address, newest wins, drain in order
    drive(1, 32'h80, 32'd1, 0, 32'h0);
    step();
    drive(1, 32'h80, 32'd2, 0, 32'h0);
    step();
    drive(0, 32'h80, 0, 0, 32'h55);
    #1 chk("t3_newest", input_data, 32'd2);
    chk("t3_head", mem_wr_data, 32'd1);
    drive(0, 32'h80, 0, 1, 32'h55);
    step();
    chk("t3_second", mem_wr_data, 32'd2);
    step();

    // 4: fill, drop with sticky overflow, then accept on simultaneous pop
    for (int i = 0; i < DEPTH; i++) begin
      drive(1, 32'h100 + 32'(i * 4), 32'hA0 + 32'(i), 0, 0);
      step();
    end
    drive(0, 32'h0, 0, 0, 0);
    #1 chk("t4_full", {31'b0, full}, 32'd1);
    drive(1, 32'h200, 32'hBAD, 0, 0);
    step();
    #1 chk("t4_ovf", {31'b0, overflow}, 32'd1);
    chk("t4_full2", {31'b0, full}, 32'd1);
    async_reset();
    for (int i = 0; i < DEPTH; i++) begin
      drive(1, 32'h100 + 32'(i * 4), 32'hB0 + 32'(i), 0, 0);
      step();
    end
    drive(1, 32'h200, 32'hC0, 1, 0);
    step();
    drive(0, 32'h200, 0, 0, 0);
    #1 chk("t4_no_ovf", {31'b0, overflow}, 32'd0);
    chk("t4_full3", {31'b0, full}, 32'd1);
    chk("t4_fwd_new", input_data, 32'hC0);
    drive(0, 32'h0, 0, 1, 0);
    for (int i = 0; i < DEPTH; i++) step();

    // 5: streaming with ready high
    for (int i = 0; i < 10; i++) begin
      drive(1, 32'h400 + 32'(i * 4), 32'h500 + 32'(i), 1, 0);
      step();
      chk("t5_notfull", {31'b0, full}, 32'd0);
    end
    drive(0, 32'h0, 0, 1, 0);
    step();

    // 6: reset mid-handshake discards buffered stores
    for (int i = 0; i < 3; i++) begin
      drive(1, 32'h300 + 32'(i * 4), 32'h600 + 32'(i), 0, 0);
      step();
    end
    drive(0, 32'h300, 0, 1, 32'hCAFEF00D);
    async_reset();
    drive(0, 32'h304, 0, 0, 32'hCAFEF00D);
    #1 chk("t6_after_rst", input_data, 32'hCAFEF00D);
    step();

    // randomized phase, alternating drain-heavy and drain-light windows
    for (int c = 0; c < 3000; c++) begin
      bit slow;
      slow = ((c / 200) % 2) == 1;
      drive($urandom_range(0, 9) < 6,
            32'h1000 + 32'($urandom_range(0, 7) * 4) + 32'($urandom_range(0, 3)),
            $urandom,
            slow ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0),
            $urandom);
      if ($urandom_range(0, 399) == 0) async_reset();
      else step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
